// File: rtl/fp_widen_seq.sv
// fp_widen_seq: sequential IEEE-754 widening converter (default binary16 -> binary32).
// Every narrow code maps to the wide value that is exactly equal to it. Zero, infinity
// and NaN keep their class, and NaNs are quietened. Subnormal inputs are normalised
// one bit per cycle in the NORM state. All other inputs convert in a single cycle.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   IN_VALID   IN_DATA holds a value to convert
//   IN_READY   converter takes IN_DATA this cycle (combinational)
//   IN_DATA    {sign, exp[INX-1:0], mant[INM-1:0]}
//   OUT_VALID  OUT_DATA/OUT_CLASS valid
//   OUT_READY  consumer accepts the output this cycle
//   OUT_DATA   {sign, exp[ONX-1:0], mant[ONM-1:0]}
//   OUT_CLASS  0 zero, 1 finite nonzero, 2 infinity, 3 NaN
module fp_widen_seq #(
  parameter int INX = 5,
  parameter int INM = 10,
  parameter int ONX = 8,
  parameter int ONM = 23
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [INX+INM:0]     IN_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [ONX+ONM:0]     OUT_DATA,
  output logic [1:0]           OUT_CLASS
);

  localparam int ON    = ONX + ONM + 1;
  localparam int IXOFF = 2 ** (INX - 1) - 1;
  localparam int OXOFF = 2 ** (ONX - 1) - 1;
  localparam int MSH   = ONM - INM;
  localparam logic [ONX-1:0] EBIAS = ONX'(OXOFF - IXOFF);
  // Starting one above the subnormal exponent lets every NORM step decrement
  // first and write e-1 on the step that finds the leading one.
  localparam logic [ONX-1:0] ESUB  = ONX'(OXOFF - IXOFF + 1);
  localparam logic [ONX-1:0] EONE  = ONX'(1);

  typedef enum logic {IDLE, NORM} state_t;
  typedef enum logic [1:0] {CL_ZERO, CL_FIN, CL_INF, CL_NAN} class_t;

  state_t         state_q, state_d;
  logic           sign_q, sign_d;
  logic [INM-1:0] sm_q, sm_d;
  logic [ONX-1:0] e_q, e_d;
  logic           out_valid_q;
  logic [ON-1:0]  out_data_q;
  class_t         out_class_q;

  logic           out_free;
  logic           ld;
  logic [ON-1:0]  ld_data;
  class_t         ld_class;

  logic           in_s;
  logic [INX-1:0] in_x;
  logic [INM-1:0] in_m;
  logic [ONM-1:0] in_mw;
  logic [INM-1:0] sm_sh;
  logic [ONM-1:0] sm_mw;

  assign in_s  = IN_DATA[INX+INM];
  assign in_x  = IN_DATA[INX+INM-1:INM];
  assign in_m  = IN_DATA[INM-1:0];
  assign in_mw = ONM'(in_m) << MSH;
  assign sm_sh = sm_q << 1;
  assign sm_mw = ONM'(sm_sh) << MSH;

  // The output register can take a new value when empty or drained this cycle.
  assign out_free = !out_valid_q || OUT_READY;
  assign IN_READY = !RST && (state_q == IDLE) && out_free;

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    sm_d     = sm_q;
    e_d      = e_q;
    ld       = 1'b0;
    ld_data  = '0;
    ld_class = CL_ZERO;
    case (state_q)
      IDLE: begin
        if (IN_VALID && IN_READY) begin
          ld_data[ON-1] = in_s;
          if (in_x == '0) begin
            if (in_m == '0) begin
              ld       = 1'b1;
              ld_class = CL_ZERO;
            end else begin
              state_d = NORM;
              sign_d  = in_s;
              sm_d    = in_m;
              e_d     = ESUB;
            end
          end else if (in_x == '1) begin
            ld                   = 1'b1;
            ld_data[ON-2 -: ONX] = '1;
            if (in_m == '0) begin
              ld_class = CL_INF;
            end else begin
              ld_data[ONM-1:0] = in_mw;
              ld_data[ONM-1]   = 1'b1;
              ld_class         = CL_NAN;
            end
          end else begin
            ld                   = 1'b1;
            ld_data[ON-2 -: ONX] = ONX'(in_x) + EBIAS;
            ld_data[ONM-1:0]     = in_mw;
            ld_class             = CL_FIN;
          end
        end
      end
      NORM: begin
        // Shifting steps never touch the output register, so only the final
        // step (leading one found) has to wait for it to be free.
        if (!sm_q[INM-1] || out_free) begin
          sm_d = sm_sh;
          e_d  = e_q - EONE;
        end
        if (sm_q[INM-1] && out_free) begin
          ld                   = 1'b1;
          ld_data[ON-1]        = sign_q;
          ld_data[ON-2 -: ONX] = e_q - EONE;
          ld_data[ONM-1:0]     = sm_mw;
          ld_class             = CL_FIN;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      sm_q        <= '0;
      e_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_class_q <= CL_ZERO;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      sm_q    <= sm_d;
      e_q     <= e_d;
      if (ld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ld_data;
        out_class_q <= ld_class;
      end else if (out_valid_q && OUT_READY) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_CLASS = out_class_q;

endmodule
